// File: rtl/rc4_stream_core.sv
// rc4_stream_core: RC4 stream cipher engine with optional keystream discard.
//
// Loads a variable-length key over a valid/ready channel, initialises the
// S-box (INIT), runs the key schedule (KSA), optionally discards the first
// DROP_N keystream words (DROP) and then XORs a valid/ready input stream with
// the keystream, one word per cycle (STREAM).
//
// Handshakes: a word moves on a channel in the cycle where valid && ready are
// both high at the rising clock edge; valid never depends on ready.
//
// Ports:
//   wb_clk_i   in   single clock, rising edge
//   wb_rst_ni  in   synchronous active-low reset
//   key_valid/key_data/key_last/key_ready   key channel (key_last ends key)
//   in_valid/in_data/in_ready               plaintext/ciphertext input
//   out_valid/out_data/out_ready            in_data XOR keystream
//   busy       out  high in INIT, KSA and DROP
//   key_err    out  sticky: over-length key seen; cleared by the next good key word
//   state_dbg  out  current FSM state (IDLE=0, LOAD=1, INIT=2, KSA=3, DROP=4, STREAM=5)
module rc4_stream_core #(
  parameter int N       = 8,
  parameter int KEY_MAX = 16,
  parameter int DROP_N  = 0
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_ni,
  input  logic         key_valid,
  input  logic [N-1:0] key_data,
  input  logic         key_last,
  output logic         key_ready,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [N-1:0] out_data,
  input  logic         out_ready,
  output logic         busy,
  output logic         key_err,
  output logic [2:0]   state_dbg
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_INIT   = 3'd2,
    ST_KSA    = 3'd3,
    ST_DROP   = 3'd4,
    ST_STREAM = 3'd5
  } state_t;

  localparam int SZ = 2 ** N;
  localparam int CW = $clog2(KEY_MAX + 1);
  localparam int KW = (KEY_MAX > 1) ? $clog2(KEY_MAX) : 1;
  localparam int DW = $clog2(DROP_N + 2);
  localparam logic [CW-1:0] KEY_FULL  = CW'(KEY_MAX);
  localparam logic [DW-1:0] DROP_LAST = DW'((DROP_N > 0) ? DROP_N - 1 : 0);

  state_t state, state_next;

  logic [N-1:0]  s_box [SZ];
  logic [N-1:0]  k_buf [KEY_MAX];
  logic [N-1:0]  i, j;
  logic [CW-1:0] cnt, len;
  logic [KW-1:0] kidx;      // i mod len, tracked incrementally during KSA
  logic [DW-1:0] drop_cnt;
  logic          flushing;  // discarding the rest of an over-length key

  logic          key_fire, in_fire, key_over;
  logic [CW-1:0] base_cnt;
  logic [N-1:0]  ksa_j;
  logic [N-1:0]  p_i, p_j, p_si, p_sj, p_t, p_k;

  // Datapath combinational terms
  always_comb begin
    key_fire = key_valid && key_ready;
    in_fire  = in_valid && in_ready;
    // A key word seen outside LOAD always starts a fresh key at K[0].
    base_cnt = (state == ST_LOAD) ? cnt : '0;
    key_over = (state == ST_LOAD) && !flushing && (cnt == KEY_FULL);
    ksa_j    = j + s_box[i] + k_buf[kidx];
    p_i      = i + 1'b1;
    p_si     = s_box[p_i];
    p_j      = j + p_si;
    p_sj     = s_box[p_j];
    p_t      = p_si + p_sj;
    // The swap lands at the clock edge, so the post-swap S[t] is forwarded
    // from the pre-swap values when t hits one of the swapped slots.
    if (p_t == p_i)      p_k = p_sj;
    else if (p_t == p_j) p_k = p_si;
    else                 p_k = s_box[p_t];
  end

  // State register
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) state <= ST_IDLE;
    else            state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_STREAM: begin
        if (key_fire) state_next = key_last ? ST_INIT : ST_LOAD;
      end
      ST_LOAD: begin
        if (key_fire) begin
          if (flushing || key_over) begin
            if (key_last) state_next = ST_IDLE;
          end else if (key_last) begin
            state_next = ST_INIT;
          end
        end
      end
      ST_INIT: if (i == '1) state_next = ST_KSA;
      ST_KSA:  if (i == '1) state_next = (DROP_N > 0) ? ST_DROP : ST_STREAM;
      ST_DROP: if (drop_cnt == DROP_LAST) state_next = ST_STREAM;
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    key_ready = (state == ST_IDLE) || (state == ST_LOAD) || (state == ST_STREAM);
    busy      = (state == ST_INIT) || (state == ST_KSA) || (state == ST_DROP);
    // A pending key word wins over input, so input is refused that cycle.
    in_ready  = (state == ST_STREAM) && (!out_valid || out_ready) && !key_valid;
    state_dbg = state;
  end

  // S-box and key buffer: contents are don't-care until written, so no reset.
  always_ff @(posedge wb_clk_i) begin
    if (key_fire && !flushing && !key_over) k_buf[base_cnt[KW-1:0]] <= key_data;
    case (state)
      ST_INIT: s_box[i] <= i;
      ST_KSA: begin
        s_box[i]     <= s_box[ksa_j];
        s_box[ksa_j] <= s_box[i];
      end
      ST_DROP: begin
        s_box[p_i] <= p_sj;
        s_box[p_j] <= p_si;
      end
      ST_STREAM: begin
        if (in_fire) begin
          s_box[p_i] <= p_sj;
          s_box[p_j] <= p_si;
        end
      end
      default: ;
    endcase
  end

  // Indices, counters and registered outputs
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      i         <= '0;
      j         <= '0;
      cnt       <= '0;
      len       <= '0;
      kidx      <= '0;
      drop_cnt  <= '0;
      flushing  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      key_err   <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          i    <= i + 1'b1;  // wraps back to 0 for KSA
          j    <= '0;
          kidx <= '0;
        end
        ST_KSA: begin
          i        <= i + 1'b1;
          j        <= (i == '1) ? '0 : ksa_j;
          kidx     <= (CW'(kidx) + CW'(1) == len) ? '0 : kidx + 1'b1;
          drop_cnt <= '0;
        end
        ST_DROP: begin
          i        <= p_i;
          j        <= p_j;
          drop_cnt <= drop_cnt + 1'b1;
        end
        ST_STREAM: begin
          if (in_fire) begin
            i         <= p_i;
            j         <= p_j;
            out_data  <= in_data ^ p_k;
            out_valid <= 1'b1;
          end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase

      // Key words abort any stream in progress.
      if (key_fire) begin
        out_valid <= 1'b0;
        if (flushing) begin
          if (key_last) begin
            flushing <= 1'b0;
            cnt      <= '0;
          end
        end else if (key_over) begin
          key_err  <= 1'b1;
          cnt      <= '0;
          flushing <= !key_last;
        end else begin
          key_err <= 1'b0;
          cnt     <= base_cnt + 1'b1;
          if (key_last) begin
            len <= base_cnt + 1'b1;
            cnt <= '0;
            i   <= '0;
            j   <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rc4_stream_core.sv
// tb_rc4_stream_core: randomized/self-checking bench for rc4_stream_core.
// Two instances share the stimulus: u_a (defaults) and u_b (KEY_MAX=4,
// DROP_N=3); sel picks which one sees valids and drives the observed outputs.
module tb_rc4_stream_core;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sel = 1'b0;
  logic       key_valid = 1'b0, key_last = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [7:0] key_data = '0, in_data = '0;
  logic       rnd_ready = 1'b0;

  logic       a_key_ready, a_in_ready, a_out_valid, a_busy, a_key_err;
  logic       b_key_ready, b_in_ready, b_out_valid, b_busy, b_key_err;
  logic [7:0] a_out_data, b_out_data;
  logic [2:0] a_state, b_state;

  logic       key_ready, in_ready, out_valid, busy, key_err;
  logic [7:0] out_data;
  logic [2:0] state_dbg;

  int         checks = 0;
  int         errors = 0;
  logic       busy_seen = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] ref_vec[$];

  // Reference model state
  logic [7:0] ms [256];
  int         mi, mj;

  always #5 clk = ~clk;

  rc4_stream_core u_a (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .key_valid(key_valid & ~sel), .key_data(key_data), .key_last(key_last),
    .key_ready(a_key_ready),
    .in_valid(in_valid & ~sel), .in_data(in_data), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(out_ready & ~sel),
    .busy(a_busy), .key_err(a_key_err), .state_dbg(a_state)
  );

  rc4_stream_core #(.N(8), .KEY_MAX(4), .DROP_N(3)) u_b (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .key_valid(key_valid & sel), .key_data(key_data), .key_last(key_last),
    .key_ready(b_key_ready),
    .in_valid(in_valid & sel), .in_data(in_data), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(out_ready & sel),
    .busy(b_busy), .key_err(b_key_err), .state_dbg(b_state)
  );

  assign key_ready = sel ? b_key_ready : a_key_ready;
  assign in_ready  = sel ? b_in_ready  : a_in_ready;
  assign out_valid = sel ? b_out_valid : a_out_valid;
  assign out_data  = sel ? b_out_data  : a_out_data;
  assign busy      = sel ? b_busy      : a_busy;
  assign key_err   = sel ? b_key_err   : a_key_err;
  assign state_dbg = sel ? b_state     : a_state;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Textbook RC4: KSA, then drop words
  task automatic model_load(input string key, input int drop);
    int len;
    int jj;
    logic [7:0] tmp, dummy;
    len = key.len();
    jj = 0;
    for (int x = 0; x < 256; x++) ms[x] = 8'(x);
    for (int x = 0; x < 256; x++) begin
      jj = (jj + int'(ms[x]) + int'(key[x % len])) % 256;
      tmp = ms[x]; ms[x] = ms[jj]; ms[jj] = tmp;
    end
    mi = 0;
    mj = 0;
    for (int d = 0; d < drop; d++) model_ks(dummy);
  endtask

  task automatic model_ks(output logic [7:0] k);
    logic [7:0] tmp;
    mi = (mi + 1) % 256;
    mj = (mj + int'(ms[mi])) % 256;
    tmp = ms[mi]; ms[mi] = ms[mj]; ms[mj] = tmp;
    k = ms[(int'(ms[mi]) + int'(ms[mj])) % 256];
  endtask

  // Monitor + scoreboard: signals are stable from negedge to the next posedge.
  always @(negedge clk) begin
    logic [7:0] ks;
    if (rst_n) begin
      if (busy) busy_seen = 1'b1;
      if (in_valid && in_ready) begin
        model_ks(ks);
        exp_q.push_back(in_data ^ ks);
      end
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        if (exp_q.size() == 0) check("scoreboard_underflow", {24'd0, out_data}, 32'hFFFF_FFFF);
        else                   check("stream_word", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic push_key_word(input logic [7:0] d, input logic last);
    logic done;
    done = 1'b0;
    key_valid = 1'b1; key_data = d; key_last = last;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      done = key_ready;
      tick();
    end
    key_valid = 1'b0; key_last = 1'b0;
    if (!done) check("key_handshake_timeout", 0, 1);
  endtask

  task automatic send_key(input string s);
    for (int k = 0; k < s.len(); k++) push_key_word(8'(s[k]), k == s.len() - 1);
  endtask

  task automatic push_in(input logic [7:0] d, output int cyc);
    logic done;
    done = 1'b0;
    cyc = 0;
    in_valid = 1'b1; in_data = d;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      done = in_ready;
      cyc++;
      tick();
    end
    in_valid = 1'b0;
    if (!done) check("in_handshake_timeout", 0, 1);
  endtask

  task automatic stream_str(input string s, output int total);
    int c;
    total = 0;
    for (int k = 0; k < s.len(); k++) begin
      push_in(8'(s[k]), c);
      total += c;
    end
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    tick();
  endtask

  task automatic drain(input int n);
    repeat (n) tick();
  endtask

  task automatic check_vec(input string tag);
    check({tag, "_count"}, got_q.size(), ref_vec.size());
    for (int k = 0; k < ref_vec.size() && k < got_q.size(); k++)
      check(tag, {24'd0, got_q[k]}, {24'd0, ref_vec[k]});
  endtask

  task automatic check_idle_outputs(input string tag);
    @(negedge clk);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_key_ready"}, key_ready, 1);
    check({tag, "_busy"},      busy, 0);
    check({tag, "_in_ready"},  in_ready, 0);
    check({tag, "_out_data"},  out_data, 0);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cyc;
    logic [7:0] key_ks[$];
    key_ks = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_key_ready", key_ready, 1);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_key_err", key_err, 0);
    check("rst_state", state_dbg, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // "Key" / "Plaintext", full throughput
    model_load("Key", 0);
    send_key("Key");
    check("busy_after_key", busy, 1);
    wait_busy(n);
    check("busy_cycles_drop0", n, 512);
    stream_str("Plaintext", n);
    check("plaintext_throughput", n, 9);
    drain(3);
    ref_vec = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    check_vec("plaintext_vec");
    got_q = {};

    // "Wiki" / "pedia", then re-key with an input word competing
    model_load("Wiki", 0);
    send_key("Wiki");
    wait_busy(n);
    stream_str("pedia", n);
    drain(3);
    ref_vec = '{8'h10, 8'h21, 8'hBF, 8'h04, 8'h20};
    check_vec("pedia_vec");
    got_q = {};
    key_valid = 1'b1; key_data = "S"; key_last = 1'b0;
    in_valid = 1'b1; in_data = 8'h55;
    @(negedge clk);
    check("rekey_priority_in_ready", in_ready, 0);
    check("rekey_key_ready", key_ready, 1);
    tick();
    key_valid = 1'b0; in_valid = 1'b0;
    check("rekey_state_load", state_dbg, 1);
    send_key("ecret");
    model_load("Secret", 0);
    wait_busy(n);
    stream_str("Attack at dawn", n);
    drain(3);
    ref_vec = '{8'h45, 8'hA0, 8'h1F, 8'h64, 8'h5F, 8'hC3, 8'h5B, 8'h38,
                8'h35, 8'h52, 8'h54, 8'h4B, 8'h9B, 8'hF5};
    check_vec("attack_vec");
    got_q = {};

    // "Key" keystream under random backpressure
    model_load("Key", 0);
    send_key("Key");
    wait_busy(n);
    rnd_ready = 1'b1;
    for (int k = 0; k < 10; k++) push_in(8'h00, cyc);
    drain(20);
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    drain(3);
    ref_vec = key_ks;
    check_vec("backpressure_ks");
    got_q = {};

    // Reset during STREAM with an output pending
    out_ready = 1'b0;
    push_in(8'h00, cyc);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_idle_outputs("rst_in_stream");
    exp_q = {};
    out_ready = 1'b1;

    // Instance B: over-length key
    sel = 1'b1;
    busy_seen = 1'b0;
    for (int k = 1; k <= 5; k++) push_key_word(8'(k * 17 + $urandom_range(0, 15)), k == 5);
    @(negedge clk);
    check("overlen_key_err", key_err, 1);
    check("overlen_state_idle", state_dbg, 0);
    check("overlen_busy_never", busy_seen, 0);
    tick();

    // Instance B: valid 3-word key clears the error, DROP_N=3
    model_load("Key", 3);
    send_key("Key");
    check("key_err_cleared", key_err, 0);
    wait_busy(n);
    check("busy_cycles_drop3", n, 515);
    for (int k = 0; k < 4; k++) push_in(8'h00, cyc);
    drain(3);
    check("drop3_count", got_q.size(), 4);
    for (int k = 0; k < 4 && k < got_q.size(); k++)
      check("drop3_ks", {24'd0, got_q[k]}, {24'd0, key_ks[k + 3]});
    got_q = {};

    // Instance B: reset during KSA
    send_key("Key");
    drain(300);
    check("ksa_busy_before_rst", busy, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_idle_outputs("rst_in_ksa");
    check("rst_in_ksa_key_err", key_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
